// File: rtl/gearbox_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_rx_pkg
// Purpose  : Shared PCS constants and the 66-bit block type used by the
//            receive gearbox and its window builder.
// Contents : DATA_W, HEAD_W, BLOCK_W, BUF_W, FILL_W, AVAIL_W, WIN_W, block_t
// Revision : 1.0 - initial release
// ============================================================================
package gearbox_rx_pkg;

  localparam int DATA_W  = 64;                 // SerDes word / payload width
  localparam int HEAD_W  = 2;                  // sync header width
  localparam int BLOCK_W = DATA_W + HEAD_W;    // 66-bit block
  localparam int BUF_W   = BLOCK_W - 1;        // residual can hold at most 65 bits
  localparam int FILL_W  = 7;                  // residual count, 0..65
  localparam int AVAIL_W = 8;                  // window occupancy, 0..129
  localparam int WIN_W   = DATA_W + BUF_W;     // 129-bit combined window

  // Header occupies the oldest two bits of the block.
  typedef struct packed {
    logic [DATA_W-1:0] payload;
    logic [HEAD_W-1:0] head;
  } block_t;

endpackage : gearbox_rx_pkg
`default_nettype wire

// File: rtl/gearbox_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_rx_if
// Purpose  : Bundle of the gearbox data/slip handshake.
// Modports : master - SerDes/block-sync side (drives words and slips)
//            slave  - gearbox side (drives blocks)
// Signals  : data_v_i, data_i, slip_v_i, valid_o, head_o, data_o,
//            slip_cnt_o (only with GEARBOX_RX_SLIP_CNT_EN)
// Revision : 1.0 - initial release
// ============================================================================
interface gearbox_rx_if;
  import gearbox_rx_pkg::*;

  logic              data_v_i;
  logic [DATA_W-1:0] data_i;
  logic              slip_v_i;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;
`ifdef GEARBOX_RX_SLIP_CNT_EN
  logic [15:0]       slip_cnt_o;

  modport master (
    output data_v_i, data_i, slip_v_i,
    input  valid_o, head_o, data_o, slip_cnt_o
  );
  modport slave (
    input  data_v_i, data_i, slip_v_i,
    output valid_o, head_o, data_o, slip_cnt_o
  );
`else
  modport master (
    output data_v_i, data_i, slip_v_i,
    input  valid_o, head_o, data_o
  );
  modport slave (
    input  data_v_i, data_i, slip_v_i,
    output valid_o, head_o, data_o
  );
`endif

endinterface : gearbox_rx_if
`default_nettype wire

// File: rtl/gearbox_rx_win.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_rx_win
// Purpose  : Combinational window builder. Appends the incoming word above
//            the residual bits, optionally drops the oldest bit (slip), and
//            splits the result into an extracted block and a new residual.
// Ports    : i_buf/i_fill   - residual bits and their count
//            i_data_v/i_data - incoming SerDes word
//            i_slip         - slip requested this cycle
//            o_emit/o_block - block extracted when >= 66 bits available
//            o_resid/o_fill - next residual and count
//            o_slip_done    - a bit was actually dropped
//            o_slip_defer   - slip requested with an empty window
// Revision : 1.0 - initial release
// ============================================================================
module gearbox_rx_win
  import gearbox_rx_pkg::*;
(
  input  logic [BUF_W-1:0]  i_buf,
  input  logic [FILL_W-1:0] i_fill,
  input  logic              i_data_v,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_slip,
  output logic              o_emit,
  output block_t            o_block,
  output logic [BUF_W-1:0]  o_resid,
  output logic [FILL_W-1:0] o_fill,
  output logic              o_slip_done,
  output logic              o_slip_defer
);

  logic [WIN_W-1:0]   w_mask;
  logic [WIN_W-1:0]   w_word;
  logic [WIN_W-1:0]   w_raw;
  logic [WIN_W-1:0]   w_win;
  logic [AVAIL_W-1:0] w_avail;
  logic [AVAIL_W-1:0] w_avail_s;
  logic [AVAIL_W-1:0] w_rem;

  // Only the low i_fill residual bits are meaningful; the word lands right
  // above them so that window bit 0 is always the oldest bit on the wire.
  assign w_mask  = (WIN_W'(1) << i_fill) - WIN_W'(1);
  assign w_word  = i_data_v ? ({{(WIN_W-DATA_W){1'b0}}, i_data} << i_fill) : '0;
  assign w_raw   = ({{(WIN_W-BUF_W){1'b0}}, i_buf} & w_mask) | w_word;
  assign w_avail = {1'b0, i_fill} + (i_data_v ? AVAIL_W'(DATA_W) : AVAIL_W'(0));

  // A slip against an empty window cannot drop anything; it is handed back
  // to the caller to be retried on the next cycle.
  assign o_slip_done  = i_slip && (w_avail != '0);
  assign o_slip_defer = i_slip && (w_avail == '0);

  assign w_win     = o_slip_done ? (w_raw >> 1) : w_raw;
  assign w_avail_s = o_slip_done ? (w_avail - AVAIL_W'(1)) : w_avail;

  assign o_emit  = (w_avail_s >= AVAIL_W'(BLOCK_W));
  assign o_block = w_win[BLOCK_W-1:0];
  assign w_rem   = w_avail_s - AVAIL_W'(BLOCK_W);

  // With no emit the occupancy is at most 65, so the low 65 window bits
  // hold everything; with an emit the leftover is at most 63 bits.
  assign o_resid = o_emit ? {{(BUF_W-(WIN_W-BLOCK_W)){1'b0}}, w_win[WIN_W-1:BLOCK_W]}
                          : w_win[BUF_W-1:0];
  assign o_fill  = o_emit ? w_rem[FILL_W-1:0] : w_avail_s[FILL_W-1:0];

endmodule : gearbox_rx_win
`default_nettype wire

// File: rtl/gearbox_rx.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_rx
// Purpose  : Receive gearbox, 64-bit SerDes words to 66-bit blocks
//            (2-bit header + 64-bit payload) with 1-bit slip support.
// Ports    : clk    - clock
//            nreset - asynchronous active-low reset
//            bus    - gearbox_rx_if.slave (word in, slip in, block out)
// Options  : GEARBOX_RX_SLIP_CNT_EN - adds the saturating 16-bit slip_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module gearbox_rx
  import gearbox_rx_pkg::*;
(
  input  logic          clk,
  input  logic          nreset,
  gearbox_rx_if.slave   bus
);

  logic [FILL_W-1:0] r_fill;
  logic [BUF_W-1:0]  r_buf;
  logic              r_pend;
  logic              r_valid;
  logic [HEAD_W-1:0] r_head;
  logic [DATA_W-1:0] r_data;

  logic              w_slip_req;
  logic              w_emit;
  block_t            w_block;
  logic [BUF_W-1:0]  w_resid;
  logic [FILL_W-1:0] w_fill;
  logic              w_slip_done;
  logic              w_slip_defer;

  // Block sync only asserts slip against a block it is currently looking at,
  // so requests outside a valid cycle are ignored. A deferred slip is
  // retried until there is a bit to drop.
  assign w_slip_req = (bus.slip_v_i & r_valid) | r_pend;

  gearbox_rx_win u_win (
    .i_buf        (r_buf),
    .i_fill       (r_fill),
    .i_data_v     (bus.data_v_i),
    .i_data       (bus.data_i),
    .i_slip       (w_slip_req),
    .o_emit       (w_emit),
    .o_block      (w_block),
    .o_resid      (w_resid),
    .o_fill       (w_fill),
    .o_slip_done  (w_slip_done),
    .o_slip_defer (w_slip_defer)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_fill  <= '0;
      r_buf   <= '0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_data  <= '0;
    end else begin
      r_fill  <= w_fill;
      r_buf   <= w_resid;
      r_pend  <= w_slip_defer;
      r_valid <= w_emit;
      // Header/payload hold their last value between blocks.
      if (w_emit) begin
        r_head <= w_block.head;
        r_data <= w_block.payload;
      end
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.head_o  = r_head;
  assign bus.data_o  = r_data;

`ifdef GEARBOX_RX_SLIP_CNT_EN
  logic [15:0] r_slip_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_slip_cnt <= '0;
    end else if (w_slip_done && (r_slip_cnt != 16'hFFFF)) begin
      r_slip_cnt <= r_slip_cnt + 16'd1;
    end
  end

  assign bus.slip_cnt_o = r_slip_cnt;
`endif

`ifndef SYNTHESIS
  // A pending slip means the residual was empty, so the following cycle
  // cannot present a block for block sync to slip against.
  a_no_double_slip: assert property (@(posedge clk) disable iff (!nreset)
    !(r_pend && bus.slip_v_i && r_valid));
`endif

endmodule : gearbox_rx
`default_nettype wire

// File: doc/gearbox_rx.md
# gearbox_rx

Receive gearbox between the SerDes parallel interface and the per-lane block sync stage. Accepts 64-bit raw words and repacks them into 66-bit blocks, presented as a 2-bit sync header plus a 64-bit payload with a valid strobe. Honours single-bit slip requests from block sync, shifting block alignment by one bit per request until lock is reached.

## Interface
- `DATA_W`, 64, SerDes word width and block payload width.
- `HEAD_W`, 2, sync header width.
- `BLOCK_W`, `DATA_W+HEAD_W` (66), block width.

- `clk`: in, 1, single clock.
- `nreset`: in, 1, asynchronous active-low reset.
- `data_v_i`: in, 1, SerDes word valid.
- `data_i`: in, DATA_W, SerDes word. Bit 0 is the oldest bit on the wire.
- `slip_v_i`: in, 1, slip request from block sync. Sampled only while `valid_o`=1.
- `valid_o`: out, 1, block valid.
- `head_o`: out, HEAD_W, sync header, equal to block bits [1:0].
- `data_o`: out, DATA_W, payload, equal to block bits [65:2].
- `slip_cnt_o`: out, 16, saturating slip count. Present only with `GEARBOX_RX_SLIP_CNT_EN`.

## Operation
- State:
  - `fill_q`: 7 bits, 0..65. Count of residual bits held.
  - `buf_q`: 65 bits. Residual bits, oldest at bit 0.
  - `pend_q`: 1 bit. Deferred slip.
  - Registered outputs.
- Per cycle, build the combined window `{data_i, buf_q[fill_q-1:0]}`, 129 bits max.
  - `avail = fill_q + (data_v_i ? 64 : 0)`.
- Slip (`slip_eff = (slip_v_i & valid_o) | pend_q`):
  - Drop the oldest window bit, window bit 0, and set `avail -= 1`.
  - If `avail` = 0 while a slip is requested, because `fill_q`=0 and `data_v_i`=0, set `pend_q` and drop nothing.
  - `pend_q` clears on the first cycle it is applied.
- Extraction:
  - If `avail >= 66`: register window bits [65:0] to `head_o`/`data_o` and set `valid_o`=1. Then `fill_next = avail - 66` and the residual is window bits [avail-1:66].
  - Else: `valid_o`=0, `fill_next = avail`, and the whole window becomes the residual.
- Steady state with no slips and `data_v_i` held high: 32 valid blocks per 33 cycles. `fill_q` follows 0, 64, 62, …, 2, 0.
- Invariant: `fill_q <= 65`. Overflow is impossible because `avail <= 129` always extracts when `avail >= 66`.
- Simultaneous `pend_q` and `slip_v_i & valid_o` cannot occur: `pend_q` implies `fill_q`=0, so the next cycle cannot emit. A formal assert checks this.
- `head_o`/`data_o` hold their last value while `valid_o`=0.
- When `data_v_i`=0, only residual bits can be extracted. Since `fill_q < 66`, `valid_o`=0.

## Timing
- Reset (async assert, sync deassert at the clk edge): `fill_q`=0, `buf_q`=0, `pend_q`=0, `valid_o`=0, `head_o`=0, `data_o`=0, `slip_cnt_o`=0.
- Latency: one cycle from the `data_i` word that completes a block to `valid_o`.
- Slip:
  - Block sync drives `slip_v_i` combinationally during the `valid_o` cycle of the offending block.
  - The drop applies in that same cycle's computation.
  - The next emitted block is already shifted by one bit, so no stale block is presented.
- Back-to-back slips on consecutive valid blocks are each honoured: one bit per valid block.
- 66 slips return alignment to the original phase, shifted by one block.
- Reset mid-operation: the partial residual is discarded and the cadence restarts at `fill_q`=0.

## Configuration
- `GEARBOX_RX_SLIP_CNT_EN` defined:
  - Adds `slip_cnt_o`, a 16-bit counter.
  - Increments on every applied slip: immediate, or deferred at the moment `pend_q` is applied.
  - Saturates at 0xFFFF and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared PCS package holds:
  - `DATA_W`, `HEAD_W`, `BLOCK_W`, `FILL_W`(7) and `WIN_W`(129) constants.
  - The typedef for the 66-bit block.
- One sub-module, `gearbox_rx_win`: combinational window builder. It concatenates the residual and the word, applies the 1-bit drop, and returns the extract and residual slices.
- The top module holds the counters, `pend_q` and the output registers.

## Test plan
- **Reset cadence:** release reset and drive `data_v_i`=1 with an incrementing bit pattern.
  - First `valid_o` appears on cycle 2.
  - Then 32 valids per 33 cycles.
  - `fill_q` returns to 0 every 33 cycles.
- **Alignment:** stream a known 66-bit block sequence with headers 01/10 at offset 0.
  - Every `head_o` is 01 or 10.
  - `data_o` matches the sent payload.
- **Slip walk:** stream blocks misaligned by 5 bits and pulse `slip_v_i` on each bad-header valid.
  - Exactly 5 slips occur, then all headers are valid.
  - `slip_cnt_o`=5.
- **Deferred slip:** force `fill_q`=0 with `data_v_i`=0 and `slip_v_i`=1 during a `valid_o` cycle.
  - `pend_q` sets.
  - The next `data_v_i` cycle drops `data_i[0]`.
  - `avail` = 63 and no emit.
- **Idle gaps:** random `data_v_i`=0 cycles.
  - No `valid_o` while idle.
  - The block stream is identical to the gap-free run.
- **Reset mid-stream:** assert `nreset` with `fill_q`=40.
  - All outputs go to 0 immediately.
  - The cadence restarts as in the reset cadence test.
